// File: rtl/decoder_pkg.sv
// Shared types and constants for the one-hot select sequencer.
//   state_t     : sequencer FSM states (IDLE, HOLD, SCAN)
//   MODE_DIRECT : command mode selecting a single code
//   MODE_SCAN   : command mode walking through every code once
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decoder.
//   idx_i    : in  SEL_W        binary code
//   onehot_o : out 2**SEL_W     one-hot image of idx_i (bit idx_i set)
module onehot_decoder #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx_i,
  output logic [2**SEL_W-1:0]   onehot_o
);

  for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_line
    assign onehot_o[gi] = (idx_i == SEL_W'(gi));
  end

endmodule

// File: rtl/decoder_nto2n_sequencer.sv
// One-hot select sequencer: registered SEL_W-to-2**SEL_W decoder with a
// valid/ready command port, programmable per-code dwell and a SCAN mode that
// walks every code once starting from the commanded code.
//   clk       : in  1        rising-edge clock
//   rst       : in  1        asynchronous active-high reset
//   enable    : in  1        block enable; low aborts a running sequence
//   in_valid  : in  1        command valid
//   in_ready  : out 1        command accept (IDLE and enabled)
//   in_lines  : in  SEL_W    start code
//   in_hold   : in  HOLD_W   dwell per code minus one
//   mode      : in  1        0 = single code, 1 = scan all codes
//   out_lines : out 2**SEL_W registered one-hot select (inverted if ACTIVE_LOW)
//   out_valid : out 1        high while a line is asserted
//   done      : out 1        one-cycle pulse on normal sequence completion
module decoder_nto2n_sequencer
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int HOLD_W     = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_lines,
  input  logic [HOLD_W-1:0]    in_hold,
  input  logic                 mode,
  output logic [2**SEL_W-1:0]  out_lines,
  output logic                 out_valid,
  output logic                 done
);

  localparam int N = 2**SEL_W;
  // Line pattern with nothing selected, in output polarity.
  localparam logic [N-1:0]   IDLE_LINES = {N{ACTIVE_LOW}};
  localparam logic [SEL_W:0] LAST_CNT   = (SEL_W+1)'(N);

  state_t              state_q;
  logic [SEL_W-1:0]    idx_q;
  logic [HOLD_W-1:0]   dwell_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [SEL_W:0]      scan_cnt_q;   // number of codes shown so far, incl. current
  logic [N-1:0]        out_lines_q;
  logic                out_valid_q;
  logic                done_q;

  logic [SEL_W-1:0]    dec_idx_d;
  logic [N-1:0]        dec_onehot;
  logic [N-1:0]        dec_lines;
  logic                accept;

  // One decoder serves both the start code (IDLE) and the next scan code.
  assign dec_idx_d = (state_q == IDLE) ? in_lines : idx_q + 1'b1;

  onehot_decoder #(.SEL_W(SEL_W)) u_dec (
    .idx_i    (dec_idx_d),
    .onehot_o (dec_onehot)
  );

  assign dec_lines = dec_onehot ^ IDLE_LINES;

  // Ready is gated by rst so it reads 0 while reset is held.
  assign in_ready = (state_q == IDLE) && enable && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dwell_q     <= '0;
      hold_q      <= '0;
      scan_cnt_q  <= '0;
      out_lines_q <= IDLE_LINES;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q       <= in_lines;
            hold_q      <= in_hold;
            dwell_q     <= in_hold;
            scan_cnt_q  <= (SEL_W+1)'(1);
            out_lines_q <= dec_lines;
            out_valid_q <= 1'b1;
            state_q     <= (mode == MODE_DIRECT) ? HOLD : SCAN;
          end
        end
        HOLD, SCAN: begin
          if (!enable) begin
            // Abort: go idle without a done pulse.
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_q     <= '0;
            scan_cnt_q  <= '0;
            out_lines_q <= IDLE_LINES;
            out_valid_q <= 1'b0;
          end else if (dwell_q != '0) begin
            // Count down so a full-scale hold never overflows.
            dwell_q <= dwell_q - 1'b1;
          end else if (state_q == HOLD || scan_cnt_q == LAST_CNT) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            scan_cnt_q  <= '0;
            out_lines_q <= IDLE_LINES;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            // Next scan code follows with no gap; idx wraps naturally.
            idx_q       <= dec_idx_d;
            dwell_q     <= hold_q;
            scan_cnt_q  <= scan_cnt_q + 1'b1;
            out_lines_q <= dec_lines;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_lines = out_lines_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_nto2n_sequencer.sv
module tb_decoder_nto2n_sequencer;

  typedef struct {
    logic [7:0] lines;
    logic       valid;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SEL_W=3, HOLD_W=4, active-high.
  logic       rst, enable, in_valid, in_ready, mode;
  logic [2:0] in_lines;
  logic [3:0] in_hold;
  logic [7:0] out_lines;
  logic       out_valid, done;

  // Second instance: SEL_W=2, active-low.
  logic       en2, v2, rdy2, mode2;
  logic [1:0] lines2;
  logic [3:0] hold2;
  logic [3:0] out2;
  logic       valid2, done2;

  decoder_nto2n_sequencer #(.SEL_W(3), .HOLD_W(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_lines(in_lines), .in_hold(in_hold), .mode(mode),
    .out_lines(out_lines), .out_valid(out_valid), .done(done)
  );

  decoder_nto2n_sequencer #(.SEL_W(2), .HOLD_W(4), .ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .in_valid(v2), .in_ready(rdy2),
    .in_lines(lines2), .in_hold(hold2), .mode(mode2),
    .out_lines(out2), .out_valid(valid2), .done(done2)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   n_cmds      = 0;
  bit   checking    = 1'b0;
  logic exp_ready   = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference behaviour: a command expands into (hold+1) cycles per code,
  // codes counting up mod 8, followed by one idle cycle carrying done.
  task automatic push_cmd(input logic [2:0] start, input logic [3:0] h, input logic m);
    int         ncodes;
    logic [7:0] one;
    one    = 8'd1;
    ncodes = m ? 8 : 1;
    for (int c = 0; c < ncodes; c++)
      for (int d = 0; d <= int'(h); d++)
        exp_q.push_back('{one << ((int'(start) + c) % 8), 1'b1, 1'b0});
    exp_q.push_back('{8'h00, 1'b0, 1'b1});
    n_cmds++;
    $display("cmd %0d: start=%0d hold=%0d mode=%s", n_cmds, start, h, m ? "SCAN" : "DIRECT");
  endtask

  // Drives one cycle of inputs just after the rising edge and updates the
  // expected-response queue; exp_q[0] is always the current cycle.
  task automatic step(input logic en, input logic v, input logic [2:0] l,
                      input logic [3:0] h, input logic m);
    @(posedge clk);
    #1;
    enable   = en;
    in_valid = v;
    in_lines = l;
    in_hold  = h;
    mode     = m;
    if (exp_q.size() == 0) exp_q.push_back('{8'h00, 1'b0, 1'b0});
    if (exp_q[0].valid && !en) begin
      // Enable low while busy: everything after this cycle is idle, no done.
      while (exp_q.size() > 1) void'(exp_q.pop_back());
    end
    exp_ready = en && !exp_q[0].valid;
    if (exp_ready && v) push_cmd(l, h, m);
    checking = 1'b1;
  endtask

  // Asynchronous reset pulse inside the current cycle, clear of any edge.
  task automatic async_rst();
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_lines", {24'h0, out_lines}, 32'h0);
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_done",  {31'h0, done}, 32'h0);
    chk("async_rst_ready", {31'h0, in_ready}, 32'h0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back('{8'h00, 1'b0, 1'b0});
    exp_ready = enable;
    $display("async reset applied mid-sequence");
  endtask

  // Monitor: one expected entry per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got lines=%h valid=%b want an expectation", out_lines, out_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_lines !== mon_e.lines || out_valid !== mon_e.valid ||
            done !== mon_e.done || in_ready !== exp_ready) begin
          miscompares++;
          $display("FAIL cycle_check: got lines=%h valid=%b done=%b ready=%b want lines=%h valid=%b done=%b ready=%b",
                   out_lines, out_valid, done, in_ready,
                   mon_e.lines, mon_e.valid, mon_e.done, exp_ready);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] want4;
    logic [3:0] one4;
    one4     = 4'b0001;
    rst      = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_lines = '0;
    in_hold  = '0;
    mode     = 1'b0;
    en2      = 1'b1;
    v2       = 1'b0;
    lines2   = '0;
    hold2    = '0;
    mode2    = 1'b0;

    #2;
    chk("reset_lines", {24'h0, out_lines}, 32'h0);
    chk("reset_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_done",  {31'h0, done}, 32'h0);
    chk("reset_ready", {31'h0, in_ready}, 32'h0);
    chk("dut2_reset_lines", {28'h0, out2}, 32'hF);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b0;

    // Active-low 2-bit instance: DIRECT code 1, then SCAN from code 3.
    @(posedge clk); #1;
    v2 = 1'b1; lines2 = 2'd1; hold2 = 4'd0; mode2 = 1'b0;
    #1;
    chk("dut2_ready", {31'h0, rdy2}, 32'h1);
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("dut2_direct_lines", {28'h0, out2}, 32'hD);
    chk("dut2_direct_valid", {31'h0, valid2}, 32'h1);
    @(posedge clk); #1;
    chk("dut2_idle_lines", {28'h0, out2}, 32'hF);
    chk("dut2_direct_done", {31'h0, done2}, 32'h1);
    v2 = 1'b1; lines2 = 2'd3; mode2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      v2    = 1'b0;
      want4 = ~(one4 << ((3 + i) % 4));
      chk("dut2_scan_lines", {28'h0, out2}, {28'h0, want4});
      chk("dut2_scan_done", {31'h0, done2}, 32'h0);
    end
    @(posedge clk); #1;
    chk("dut2_scan_end_lines", {28'h0, out2}, 32'hF);
    chk("dut2_scan_end_done", {31'h0, done2}, 32'h1);

    // Main instance, directed cases.
    step(1'b1, 1'b1, 3'd5, 4'd0, 1'b0);                  // DIRECT 5, single cycle
    repeat (3) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    repeat (10) step(1'b1, 1'b1, 3'd2, 4'd3, 1'b0);      // dwell 4, in_valid held
    repeat (2) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 3'd6, 4'd1, 1'b1);                  // SCAN with wrap
    repeat (20) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 3'd0, 4'd1, 1'b1);                  // abort on third code
    repeat (4) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 3'd4, 4'd0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 3'd3, 4'd15, 1'b0);                 // full-scale dwell
    repeat (20) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 4'd0, 1'b1);                  // SCAN from N-1
    repeat (10) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 3'd6, 4'd0, 1'b1);                  // reset mid-scan
    repeat (3) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
    async_rst();
    repeat (2) step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      logic       r_en, r_v, r_m;
      logic [2:0] r_l;
      logic [3:0] r_h;
      r_en = ($urandom_range(0, 99) < 96);
      r_v  = ($urandom_range(0, 2) != 0);
      r_l  = 3'($urandom_range(0, 7));
      r_h  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      r_m  = 1'($urandom_range(0, 1));
      step(r_en, r_v, r_l, r_h, r_m);
      if ($urandom_range(0, 299) == 0) async_rst();
    end

    @(posedge clk); #1;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
